instr_fetch_unit: RTL and testbench

- Instruction-fetch stage placed directly upstream of the 19-bit CPU core.
- Holds the program in a local instruction memory, which is loaded once through a valid/ready stream after reset.
- In RUN, it returns the 19-bit instruction addressed by the core's pc on every clock.
- It also tracks control-flow redirects (jumps, branches, calls, returns) and flags fetches beyond the loaded program.

---
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: program memory loaded once over a valid/ready stream, then
// served to the core by pc with one-cycle latency. Optional macro: FETCH_DECRYPT_EN.
module instr_fetch_unit #(
    parameter int          DEPTH    = 256,
    parameter int          AW       = $clog2(DEPTH),
    parameter logic [18:0] NOP_WORD = 19'h44000,
    parameter logic [18:0] ENC_KEY  = 19'h1F1F1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [18:0]   load_data,
    input  logic          load_last,
    input  logic [18:0]   pc,
    output logic [18:0]   instruction,
    output logic          instr_valid,
    output logic [1:0]    state,
    output logic [AW:0]   prog_len,
    output logic [15:0]   redirect_cnt,
    output logic          fetch_fault
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   LEN_ONE  = 1;
    localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

`ifdef FETCH_DECRYPT_EN
    localparam logic [18:0] DEC_KEY = ENC_KEY;
`else
    // Stored words are plaintext; the key is masked off so the read path is a pass-through.
    localparam logic [18:0] DEC_KEY = ENC_KEY & 19'h00000;
`endif

    state_t          state_reg, state_next;
    logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [AW:0]     prog_len_reg, prog_len_next;
    logic [15:0]     redirect_cnt_reg, redirect_cnt_next;
    logic            fault_reg, fault_next;
    logic [18:0]     prev_pc_reg, prev_pc_next;
    logic            prev_valid_reg, prev_valid_next;
    logic            valid_reg, valid_next;
    logic            wr_en;
    logic [18:0]     rd_word_reg;
    logic [18:0]     prog_len_ext;

    logic [18:0] mem [DEPTH];

    assign prog_len_ext = {{(19 - AW - 1){1'b0}}, prog_len_reg};

    // Plain array with a registered read so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= load_data;
        end
        rd_word_reg <= mem[pc[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_LOAD;
            wr_ptr_reg       <= '0;
            prog_len_reg     <= '0;
            redirect_cnt_reg <= '0;
            fault_reg        <= 1'b0;
            prev_pc_reg      <= '0;
            prev_valid_reg   <= 1'b0;
            valid_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            wr_ptr_reg       <= wr_ptr_next;
            prog_len_reg     <= prog_len_next;
            redirect_cnt_reg <= redirect_cnt_next;
            fault_reg        <= fault_next;
            prev_pc_reg      <= prev_pc_next;
            prev_valid_reg   <= prev_valid_next;
            valid_reg        <= valid_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        wr_ptr_next       = wr_ptr_reg;
        prog_len_next     = prog_len_reg;
        redirect_cnt_next = redirect_cnt_reg;
        fault_next        = fault_reg;
        prev_pc_next      = prev_pc_reg;
        prev_valid_next   = prev_valid_reg;
        valid_next        = 1'b0;
        wr_en             = 1'b0;
        load_ready        = 1'b0;

        case (state_reg)
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr_reg + PTR_ONE;
                    // The word is written in the same cycle that the exit to RUN is taken.
                    if (load_last || (wr_ptr_reg == PTR_LAST)) begin
                        state_next    = ST_RUN;
                        prog_len_next = {1'b0, wr_ptr_reg} + LEN_ONE;
                    end
                end
            end
            ST_RUN: begin
                prev_pc_next    = pc;
                prev_valid_next = 1'b1;
                if (prev_valid_reg && (pc != (prev_pc_reg + 19'd1)) && (pc != prev_pc_reg)
                    && (redirect_cnt_reg != CNT_MAX)) begin
                    redirect_cnt_next = redirect_cnt_reg + 16'd1;
                end
                if (pc >= prog_len_ext) begin
                    fault_next = 1'b1;
                    state_next = ST_FAULT;
                end else begin
                    valid_next = 1'b1;
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_FAULT;
                fault_next = 1'b1;
            end
        endcase
    end

    assign instruction  = valid_reg ? (rd_word_reg ^ DEC_KEY) : NOP_WORD;
    assign instr_valid  = valid_reg;
    assign state        = state_reg;
    assign prog_len     = prog_len_reg;
    assign redirect_cnt = redirect_cnt_reg;
    assign fetch_fault  = fault_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: load, fetch, redirect counting,
// fault handling, full-depth load, reset mid-load and the optional decrypt path.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [18:0] load_data;
    logic        load_last;
    logic [18:0] pc;
    logic [18:0] instruction;
    logic        instr_valid;
    logic [1:0]  state;
    logic [8:0]  prog_len;
    logic [15:0] redirect_cnt;
    logic        fetch_fault;

    int checks;
    int errors;

`ifdef FETCH_DECRYPT_EN
    localparam logic [18:0] KEY = 19'h1F1F1;
`else
    localparam logic [18:0] KEY = 19'h00000;
`endif
    localparam logic [18:0] NOP = 19'h44000;

    logic [18:0] words4 [4];

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .pc           (pc),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .state        (state),
        .prog_len     (prog_len),
        .redirect_cnt (redirect_cnt),
        .fetch_fault  (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        load_valid = 1'b0;
        load_last  = 1'b0;
        pc         = 19'd0;
        rst        = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic load_word(input logic [18:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        $display("load data=%05h last=%0d -> state=%0d prog_len=%0d", d, last, state, prog_len);
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 19'd0;
        pc         = 19'd0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        $display("reset: state=%0d ready=%0d valid=%0d instr=%05h len=%0d",
                 state, load_ready, instr_valid, instruction, prog_len);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0d exp 1", load_ready); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", instr_valid); end
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr got %05h exp %05h", instruction, NOP); end
        checks++; if (prog_len !== 9'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", prog_len); end
        checks++; if (redirect_cnt !== 16'd0) begin errors++; $display("FAIL reset_redir got %0d exp 0", redirect_cnt); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0d exp 0", fetch_fault); end
    endtask

    task automatic test_load4();
        for (int i = 0; i < 4; i++) begin
            load_word(words4[i], (i == 3));
        end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL load4_state got %0d exp 1", state); end
        checks++; if (prog_len !== 9'd4) begin errors++; $display("FAIL load4_len got %0d exp 4", prog_len); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load4_ready got %0d exp 0", load_ready); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL load4_valid got %0d exp 0", instr_valid); end
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 4; i++) begin
            pc = 19'(i);
            tick();
            $display("fetch pc=%0d -> instr=%05h valid=%0d", i, instruction, instr_valid);
            checks++; if (instruction !== (words4[i] ^ KEY)) begin errors++; $display("FAIL fetch_instr pc=%0d got %05h exp %05h", i, instruction, words4[i] ^ KEY); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid pc=%0d got %0d exp 1", i, instr_valid); end
        end
        checks++; if (redirect_cnt !== 16'd0) begin errors++; $display("FAIL fetch_redir got %0d exp 0", redirect_cnt); end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL fetch_state got %0d exp 1", state); end
    endtask

    task automatic test_redirect_fault();
        logic [18:0] seq [5];
        seq[0] = 19'd0; seq[1] = 19'd1; seq[2] = 19'd3; seq[3] = 19'd3; seq[4] = 19'd0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_word(words4[i], (i == 3));
        end
        for (int i = 0; i < 5; i++) begin
            pc = seq[i];
            tick();
            $display("redirect pc=%0d -> instr=%05h cnt=%0d", seq[i], instruction, redirect_cnt);
            checks++; if (instruction !== (words4[seq[i]] ^ KEY)) begin errors++; $display("FAIL redir_instr pc=%0d got %05h exp %05h", seq[i], instruction, words4[seq[i]] ^ KEY); end
        end
        checks++; if (redirect_cnt !== 16'd2) begin errors++; $display("FAIL redir_cnt got %0d exp 2", redirect_cnt); end
        pc = 19'd4;
        tick();
        $display("fault pc=4 -> state=%0d instr=%05h fault=%0d cnt=%0d", state, instruction, fetch_fault, redirect_cnt);
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_flag got %0d exp 1", fetch_fault); end
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL fault_state got %0d exp 2", state); end
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL fault_instr got %05h exp %05h", instruction, NOP); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fault_valid got %0d exp 0", instr_valid); end
        checks++; if (redirect_cnt !== 16'd3) begin errors++; $display("FAIL fault_cnt got %0d exp 3", redirect_cnt); end
        pc = 19'd1;
        tick();
        pc = 19'd9;
        tick();
        pc = 19'd2;
        tick();
        $display("post-fault -> state=%0d instr=%05h cnt=%0d", state, instruction, redirect_cnt);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL sticky_state got %0d exp 2", state); end
        checks++; if (redirect_cnt !== 16'd3) begin errors++; $display("FAIL frozen_cnt got %0d exp 3", redirect_cnt); end
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL sticky_instr got %05h exp %05h", instruction, NOP); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL sticky_ready got %0d exp 0", load_ready); end
    endtask

    task automatic test_full_depth();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                checks++; if (state !== 2'b00) begin errors++; $display("FAIL depth_early_exit got %0d exp 0", state); end
                checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL depth_ready got %0d exp 1", load_ready); end
            end
            load_valid = 1'b1;
            load_data  = 19'h30000 | 19'(i);
            load_last  = 1'b0;
            tick();
        end
        load_valid = 1'b0;
        $display("full load 256 words -> state=%0d prog_len=%0d", state, prog_len);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL depth_state got %0d exp 1", state); end
        checks++; if (prog_len !== 9'd256) begin errors++; $display("FAIL depth_len got %0d exp 256", prog_len); end
        pc = 19'd255;
        tick();
        $display("fetch pc=255 -> instr=%05h valid=%0d", instruction, instr_valid);
        checks++; if (instruction !== (19'h300FF ^ KEY)) begin errors++; $display("FAIL depth_instr got %05h exp %05h", instruction, 19'h300FF ^ KEY); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL depth_valid got %0d exp 1", instr_valid); end
        pc = 19'h00100;
        tick();
        $display("fetch pc=100h -> state=%0d fault=%0d", state, fetch_fault);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL depth_fault_state got %0d exp 2", state); end
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL depth_fault got %0d exp 1", fetch_fault); end
    endtask

    task automatic test_reset_midload();
        // Asynchronous reset taken mid-cycle from FAULT.
        rst = 1'b0;
        #2;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL async_state got %0d exp 0", state); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL async_fault got %0d exp 0", fetch_fault); end
        tick();
        rst = 1'b1;
        pc  = 19'd0;
        load_word(19'h11111, 1'b0);
        load_word(19'h22222, 1'b0);
        rst = 1'b0;
        #2;
        tick();
        rst = 1'b1;
        load_word(19'h0ABCD, 1'b1);
        checks++; if (prog_len !== 9'd1) begin errors++; $display("FAIL midload_len got %0d exp 1", prog_len); end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL midload_state got %0d exp 1", state); end
        pc = 19'd0;
        tick();
        $display("fetch pc=0 -> instr=%05h valid=%0d", instruction, instr_valid);
        checks++; if (instruction !== (19'h0ABCD ^ KEY)) begin errors++; $display("FAIL midload_instr got %05h exp %05h", instruction, 19'h0ABCD ^ KEY); end
        pc = 19'd1;
        tick();
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL midload_fault got %0d exp 2", state); end
    endtask

    task automatic test_decrypt();
        logic [18:0] exp_word;
        exp_word = 19'h1F1F1 ^ KEY;
        do_reset();
        load_word(19'h1F1F1, 1'b1);
        pc = 19'd0;
        tick();
        $display("decrypt pc=0 -> instr=%05h", instruction);
        checks++; if (instruction !== exp_word) begin errors++; $display("FAIL decrypt_instr got %05h exp %05h", instruction, exp_word); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        words4[0] = 19'h00441;
        words4[1] = 19'h04882;
        words4[2] = 19'h28005;
        words4[3] = 19'h1C0C3;
        test_reset();
        test_load4();
        test_fetch();
        test_redirect_fault();
        test_full_depth();
        test_reset_midload();
        test_decrypt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
